// File: rtl/mcif_arb_cfg_regfile.sv
// CSB register file for the MCIF read/write arbiters.
// Weights and outstanding limits are double-buffered behind an idle-gated commit.
module mcif_arb_cfg_regfile #(
    parameter int          NUM_RD_CLIENTS = 12,
    parameter int          NUM_WR_CLIENTS = 8,
    parameter logic [11:0] BASE           = 12'h000
) (
    input  logic                        nvdla_core_clk,
    input  logic                        nvdla_core_rstn,
    input  logic [11:0]                 reg_offset,
    input  logic                        reg_wr_en,
    input  logic [31:0]                 reg_wr_data,
    input  logic                        reg_rd_en,
    output logic [31:0]                 reg_rd_data,
    input  logic                        idle,
    output logic [8*NUM_RD_CLIENTS-1:0] rd_weight,
    output logic [8*NUM_WR_CLIENTS-1:0] wr_weight,
    output logic [7:0]                  rd_os_cnt,
    output logic [7:0]                  wr_os_cnt,
    output logic                        cfg_pending,
    output logic                        cfg_commit_done
);
    localparam int RD_WORDS = (NUM_RD_CLIENTS + 3) / 4;
    localparam int WR_WORDS = (NUM_WR_CLIENTS + 3) / 4;

    typedef enum logic {IDLE_CFG, PENDING} state_t;

    state_t                      state;
    logic [11:0]                 off;
    logic [3:0]                  widx;
    logic                        rd_hit, wr_hit, os_hit, st_hit, ctl_hit, err_hit;
    logic                        mapped, commit_req, abort_req, inv_wr, ro_wr;
    logic [8*NUM_RD_CLIENTS-1:0] rd_wt_sh;
    logic [8*NUM_WR_CLIENTS-1:0] wr_wt_sh;
    logic [7:0]                  rd_os_sh, wr_os_sh;
    logic [7:0]                  err_inv, err_ro;
    logic [31:0]                 rd_val;

    assign off     = reg_offset - BASE;
    assign widx    = off[5:2];
    assign rd_hit  = (off[11:6] == 6'd0) && (off[1:0] == 2'd0)
                     && (int'(widx) < RD_WORDS);
    assign wr_hit  = (off[11:6] == 6'd1) && (off[1:0] == 2'd0)
                     && (int'(widx) < WR_WORDS);
    assign os_hit  = (off == 12'h080);
    assign st_hit  = (off == 12'h084);
    assign ctl_hit = (off == 12'h088);
    assign err_hit = (off == 12'h08C);
    assign mapped  = rd_hit | wr_hit | os_hit | st_hit | ctl_hit | err_hit;

    assign commit_req = reg_wr_en && ctl_hit && reg_wr_data[0] && !reg_wr_data[1];
    assign abort_req  = reg_wr_en && ctl_hit && reg_wr_data[1];
    assign inv_wr     = reg_wr_en && !mapped;
    assign ro_wr      = reg_wr_en && st_hit;

    // Shadow copies: lanes past the client count are never stored.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            rd_wt_sh <= {NUM_RD_CLIENTS{8'h01}};
            wr_wt_sh <= {NUM_WR_CLIENTS{8'h01}};
            rd_os_sh <= 8'hFF;
            wr_os_sh <= 8'hFF;
        end else if (reg_wr_en) begin
            for (int c = 0; c < NUM_RD_CLIENTS; c++)
                if (rd_hit && int'(widx) == c / 4)
                    rd_wt_sh[8*c +: 8] <= reg_wr_data[8*(c%4) +: 8];
            for (int c = 0; c < NUM_WR_CLIENTS; c++)
                if (wr_hit && int'(widx) == c / 4)
                    wr_wt_sh[8*c +: 8] <= reg_wr_data[8*(c%4) +: 8];
            if (os_hit) begin
                rd_os_sh <= reg_wr_data[7:0];
                wr_os_sh <= reg_wr_data[15:8];
            end
        end
    end

    // Abort takes priority over an apply in the same cycle.
    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            state           <= IDLE_CFG;
            cfg_pending     <= 1'b0;
            cfg_commit_done <= 1'b0;
            rd_weight       <= {NUM_RD_CLIENTS{8'h01}};
            wr_weight       <= {NUM_WR_CLIENTS{8'h01}};
            rd_os_cnt       <= 8'hFF;
            wr_os_cnt       <= 8'hFF;
        end else begin
            cfg_commit_done <= 1'b0;
            unique case (state)
                IDLE_CFG: begin
                    if (commit_req) begin
                        state       <= PENDING;
                        cfg_pending <= 1'b1;
                    end
                end
                PENDING: begin
                    if (abort_req) begin
                        state       <= IDLE_CFG;
                        cfg_pending <= 1'b0;
                    end else if (idle) begin
                        state           <= IDLE_CFG;
                        cfg_pending     <= 1'b0;
                        cfg_commit_done <= 1'b1;
                        rd_weight       <= rd_wt_sh;
                        wr_weight       <= wr_wt_sh;
                        rd_os_cnt       <= rd_os_sh;
                        wr_os_cnt       <= wr_os_sh;
                    end
                end
                default: state <= IDLE_CFG;
            endcase
        end
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            err_inv <= 8'h00;
            err_ro  <= 8'h00;
        end else if (reg_wr_en && err_hit) begin
            err_inv <= 8'h00;
            err_ro  <= 8'h00;
        end else begin
            if (inv_wr && err_inv != 8'hFF) err_inv <= err_inv + 8'd1;
            if (ro_wr && err_ro != 8'hFF)   err_ro  <= err_ro + 8'd1;
        end
    end

    always_comb begin
        rd_val = 32'h0;
        unique case (1'b1)
            rd_hit: begin
                for (int c = 0; c < NUM_RD_CLIENTS; c++)
                    if (int'(widx) == c / 4)
                        rd_val[8*(c%4) +: 8] = rd_wt_sh[8*c +: 8];
            end
            wr_hit: begin
                for (int c = 0; c < NUM_WR_CLIENTS; c++)
                    if (int'(widx) == c / 4)
                        rd_val[8*(c%4) +: 8] = wr_wt_sh[8*c +: 8];
            end
            os_hit:  rd_val = {16'h0, wr_os_sh, rd_os_sh};
            st_hit:  rd_val = {23'h0, idle, 7'h0, cfg_pending};
            err_hit: rd_val = {16'h0, err_ro, err_inv};
            default: rd_val = 32'h0;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) reg_rd_data <= 32'h0;
        else if (reg_rd_en)   reg_rd_data <= rd_val;
    end
endmodule

// File: tb/tb_mcif_arb_cfg_regfile.sv
// Directed bench for mcif_arb_cfg_regfile with five read and eight write clients.
// Each scenario task drives its own vectors and compares against hand-computed values.
module tb_mcif_arb_cfg_regfile;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [11:0] reg_offset = 12'h0;
    logic        reg_wr_en = 1'b0;
    logic [31:0] reg_wr_data = 32'h0;
    logic        reg_rd_en = 1'b0;
    logic [31:0] reg_rd_data;
    logic        idle = 1'b0;
    logic [39:0] rd_weight;
    logic [63:0] wr_weight;
    logic [7:0]  rd_os_cnt, wr_os_cnt;
    logic        cfg_pending, cfg_commit_done;

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] rv;

    mcif_arb_cfg_regfile #(
        .NUM_RD_CLIENTS(5),
        .NUM_WR_CLIENTS(8),
        .BASE(12'h000)
    ) dut (
        .nvdla_core_clk(clk),
        .nvdla_core_rstn(rstn),
        .reg_offset(reg_offset),
        .reg_wr_en(reg_wr_en),
        .reg_wr_data(reg_wr_data),
        .reg_rd_en(reg_rd_en),
        .reg_rd_data(reg_rd_data),
        .idle(idle),
        .rd_weight(rd_weight),
        .wr_weight(wr_weight),
        .rd_os_cnt(rd_os_cnt),
        .wr_os_cnt(wr_os_cnt),
        .cfg_pending(cfg_pending),
        .cfg_commit_done(cfg_commit_done)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [11:0] o, input logic [31:0] d);
        reg_offset = o;
        reg_wr_data = d;
        reg_wr_en = 1'b1;
        @(posedge clk);
        #1;
        reg_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [11:0] o, output logic [31:0] d);
        reg_offset = o;
        reg_rd_en = 1'b1;
        @(posedge clk);
        #1;
        reg_rd_en = 1'b0;
        d = reg_rd_data;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (reg_rd_data !== 32'h0) begin n_fail++; $display("FAIL rst_rd_data got %h want 0", reg_rd_data); end
        rstn = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (rd_weight !== 40'h0101010101) begin n_fail++; $display("FAIL rst_rd_weight got %h want 0101010101", rd_weight); end
        n_cmp++; if (wr_weight !== 64'h0101010101010101) begin n_fail++; $display("FAIL rst_wr_weight got %h", wr_weight); end
        n_cmp++; if (rd_os_cnt !== 8'hFF || wr_os_cnt !== 8'hFF) begin n_fail++; $display("FAIL rst_os got %h/%h want ff/ff", rd_os_cnt, wr_os_cnt); end
        n_cmp++; if (cfg_pending !== 1'b0 || cfg_commit_done !== 1'b0) begin n_fail++; $display("FAIL rst_fsm got %b%b want 00", cfg_pending, cfg_commit_done); end
        rd(12'h08C, rv);
        n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL rst_err got %h want 0", rv); end
        rd(12'h080, rv);
        n_cmp++; if (rv !== 32'h0000FFFF) begin n_fail++; $display("FAIL rst_os_read got %h want 0000ffff", rv); end
    endtask

    task automatic test_shadow();
        idle = 1'b1;
        wr(12'h000, 32'h04030201);
        wr(12'h080, 32'h00001020);
        rd(12'h000, rv);
        n_cmp++; if (rv !== 32'h04030201) begin n_fail++; $display("FAIL shadow_read got %h want 04030201", rv); end
        rd(12'h080, rv);
        n_cmp++; if (rv !== 32'h00001020) begin n_fail++; $display("FAIL shadow_os got %h want 00001020", rv); end
        n_cmp++; if (rd_weight !== 40'h0101010101) begin n_fail++; $display("FAIL shadow_active got %h want 0101010101", rd_weight); end
        n_cmp++; if (rd_os_cnt !== 8'hFF) begin n_fail++; $display("FAIL shadow_os_active got %h want ff", rd_os_cnt); end
    endtask

    task automatic test_commit();
        idle = 1'b0;
        wr(12'h088, 32'h1);
        for (int i = 0; i < 10; i++) begin
            n_cmp++; if (cfg_pending !== 1'b1 || rd_weight !== 40'h0101010101) begin n_fail++; $display("FAIL commit_hold cyc %0d pend %b wt %h", i, cfg_pending, rd_weight); end
            @(posedge clk);
            #1;
        end
        rd(12'h084, rv);
        n_cmp++; if (rv !== 32'h00000001) begin n_fail++; $display("FAIL status got %h want 00000001", rv); end
        rd(12'h088, rv);
        n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL ctrl_read got %h want 0", rv); end
        idle = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (rd_weight !== 40'h0104030201) begin n_fail++; $display("FAIL commit_wt got %h want 0104030201", rd_weight); end
        n_cmp++; if (rd_os_cnt !== 8'h20 || wr_os_cnt !== 8'h10) begin n_fail++; $display("FAIL commit_os got %h/%h want 20/10", rd_os_cnt, wr_os_cnt); end
        n_cmp++; if (cfg_commit_done !== 1'b1 || cfg_pending !== 1'b0) begin n_fail++; $display("FAIL commit_pulse got done %b pend %b", cfg_commit_done, cfg_pending); end
        @(posedge clk);
        #1;
        n_cmp++; if (cfg_commit_done !== 1'b0) begin n_fail++; $display("FAIL commit_pulse_width got %b want 0", cfg_commit_done); end
    endtask

    task automatic test_abort();
        idle = 1'b0;
        wr(12'h000, 32'h0A0B0C0D);
        wr(12'h088, 32'h1);
        n_cmp++; if (cfg_pending !== 1'b1) begin n_fail++; $display("FAIL abort_arm got %b want 1", cfg_pending); end
        wr(12'h088, 32'h3);
        n_cmp++; if (cfg_pending !== 1'b0 || cfg_commit_done !== 1'b0) begin n_fail++; $display("FAIL abort got pend %b done %b", cfg_pending, cfg_commit_done); end
        idle = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (cfg_commit_done !== 1'b0 || rd_weight !== 40'h0104030201) begin n_fail++; $display("FAIL abort_idle cyc %0d done %b wt %h", i, cfg_commit_done, rd_weight); end
        end
        wr(12'h088, 32'h3);
        n_cmp++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL both_bits got %b want 0", cfg_pending); end
    endtask

    task automatic test_partial_lanes();
        wr(12'h004, 32'hFFFFFFFF);
        rd(12'h004, rv);
        n_cmp++; if (rv !== 32'h000000FF) begin n_fail++; $display("FAIL partial_read got %h want 000000ff", rv); end
        rd(12'h08C, rv);
        n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL partial_err got %h want 0", rv); end
        wr(12'h008, 32'h12345678);
        rd(12'h08C, rv);
        n_cmp++; if (rv !== 32'h00000001) begin n_fail++; $display("FAIL past_words_err got %h want 00000001", rv); end
        rd(12'h008, rv);
        n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL unmapped_read got %h want 0", rv); end
        wr(12'h08C, 32'h0);
    endtask

    task automatic test_err();
        for (int i = 0; i < 300; i++) wr(12'h0FC, 32'h0);
        wr(12'h084, 32'h1);
        wr(12'h084, 32'h1);
        rd(12'h08C, rv);
        n_cmp++; if (rv !== 32'h000002FF) begin n_fail++; $display("FAIL err_sat got %h want 000002ff", rv); end
        wr(12'h08C, 32'hFFFFFFFF);
        rd(12'h08C, rv);
        n_cmp++; if (rv !== 32'h0) begin n_fail++; $display("FAIL err_clear got %h want 0", rv); end
    endtask

    task automatic test_back_to_back();
        reg_offset = 12'h040;
        reg_wr_data = 32'h11223344;
        reg_wr_en = 1'b1;
        reg_rd_en = 1'b1;
        @(posedge clk);
        #1;
        reg_wr_en = 1'b0;
        reg_rd_en = 1'b0;
        n_cmp++; if (reg_rd_data !== 32'h01010101) begin n_fail++; $display("FAIL rw_same got %h want 01010101", reg_rd_data); end
        rd(12'h040, rv);
        n_cmp++; if (rv !== 32'h11223344) begin n_fail++; $display("FAIL rw_after got %h want 11223344", rv); end
        rd(12'h0FC, rv);
        n_cmp++; if (reg_rd_data !== 32'h0) begin n_fail++; $display("FAIL rd_hold got %h want 0", reg_rd_data); end
    endtask

    task automatic test_apply_collision();
        idle = 1'b0;
        wr(12'h088, 32'h1);
        idle = 1'b1;
        wr(12'h000, 32'h99999999);
        n_cmp++; if (rd_weight !== 40'hFF0A0B0C0D) begin n_fail++; $display("FAIL coll_active got %h want ff0a0b0c0d", rd_weight); end
        n_cmp++; if (wr_weight !== 64'h0101010111223344) begin n_fail++; $display("FAIL coll_wr_wt got %h", wr_weight); end
        n_cmp++; if (cfg_commit_done !== 1'b1 || cfg_pending !== 1'b0) begin n_fail++; $display("FAIL coll_fsm got done %b pend %b", cfg_commit_done, cfg_pending); end
        rd(12'h000, rv);
        n_cmp++; if (rv !== 32'h99999999) begin n_fail++; $display("FAIL coll_shadow got %h want 99999999", rv); end
        n_cmp++; if (cfg_pending !== 1'b0) begin n_fail++; $display("FAIL coll_rearm got %b want 0", cfg_pending); end
    endtask

    task automatic test_reset_mid();
        idle = 1'b0;
        wr(12'h088, 32'h1);
        rstn = 1'b0;
        #1;
        n_cmp++; if (cfg_pending !== 1'b0 || rd_weight !== 40'h0101010101) begin n_fail++; $display("FAIL mid_reset got pend %b wt %h", cfg_pending, rd_weight); end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        idle = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (cfg_commit_done !== 1'b0 || rd_weight !== 40'h0101010101) begin n_fail++; $display("FAIL mid_reset_lost got done %b wt %h", cfg_commit_done, rd_weight); end
        rd(12'h000, rv);
        n_cmp++; if (rv !== 32'h01010101) begin n_fail++; $display("FAIL mid_reset_shadow got %h want 01010101", rv); end
    endtask

    initial begin
        test_reset();
        test_shadow();
        test_commit();
        test_abort();
        test_partial_lanes();
        test_err();
        test_back_to_back();
        test_apply_collision();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mcif_arb_cfg_regfile.md
# mcif_arb_cfg_regfile

Parametrised CSB register file for the MCIF read/write arbiters. It supports configurable read and write client counts. Weight and outstanding-count fields are double-buffered: software programs shadow copies, and they reach the arbiter only through an idle-gated commit. It also adds a registered read path and saturating error counters for illegal writes. It sits between the CSB slave decode and the MCIF read/write arbiters.

## Interface
- NUM_RD_CLIENTS, 12, number of read clients (1..64); one 8-bit weight each
- NUM_WR_CLIENTS, 8, number of write clients (1..64); one 8-bit weight each
- BASE, 12'h000, 12-bit offset base of the register window
- nvdla_core_clk  in  1  sole clock
- nvdla_core_rstn  in  1  reset, asynchronous assert, active-low
- reg_offset  in  12  byte offset of CSB access
- reg_wr_en  in  1  write strobe, one cycle per write
- reg_wr_data  in  32  write data
- reg_rd_en  in  1  read strobe, one cycle per read
- reg_rd_data  out  32  read data, registered
- idle  in  1  arbiter idle; commit permitted only when high
- rd_weight  out  8*NUM_RD_CLIENTS  active read weights, client i at [8i+7:8i]
- wr_weight  out  8*NUM_WR_CLIENTS  active write weights, same packing
- rd_os_cnt, wr_os_cnt  out  8 each  active outstanding limits
- cfg_pending  out  1  commit requested, not yet applied
- cfg_commit_done  out  1  one-cycle pulse on commit apply

## Operation
- Register map (offset relative to BASE):
  - RD_WT[i] at 0x000+4i, i < ceil(NUM_RD_CLIENTS/4). Client 4i+k occupies bits [8k+7:8k].
  - WR_WT[j] at 0x040+4j, with the same packing.
  - OS_CNT at 0x080: [7:0] rd, [15:8] wr.
  - STATUS at 0x084, read-only: [0] cfg_pending, [8] idle.
  - CTRL at 0x088: [0] commit, [1] abort, self-clearing, reads 0.
  - ERR at 0x08C: [7:0] invalid-write count, [15:8] read-only-write count. Any write clears both fields.
- Byte lanes in RD_WT/WR_WT whose client index is at or beyond NUM_*_CLIENTS: writes are ignored and they read 0. Such writes are still valid.
- Shadow registers: writes to RD_WT, WR_WT and OS_CNT update the shadow copies only. Reads of these registers return shadow values.
- Active registers drive rd_weight, wr_weight, rd_os_cnt and wr_os_cnt.
- Commit FSM, states IDLE_CFG and PENDING:
  - IDLE_CFG -> PENDING on a CTRL write with commit=1 and abort=0.
  - PENDING & idle -> IDLE_CFG. On that edge, active <= shadow for all fields and cfg_commit_done pulses.
  - PENDING & CTRL write with abort=1 -> IDLE_CFG with no copy and no pulse.
  - A commit write while already PENDING has no effect.
  - commit and abort written together: abort wins.
- Invalid write is a write to any offset outside the map. It increments ERR[7:0], saturating at 0xFF.
- A write to STATUS increments ERR[15:8], saturating at 0xFF.
- A write to ERR clears both fields, even if an error event occurs in the same cycle.
- Reset values:
  - All shadow and active weights 0x01; os_cnt shadow and active 0xFF.
  - FSM in IDLE_CFG, cfg_pending 0, cfg_commit_done 0.
  - ERR 0, reg_rd_data 0.

## Timing
- Writes take effect on the shadow registers at the clock edge where reg_wr_en is sampled.
- Read: reg_rd_en sampled at edge N. reg_rd_data carries the value at edge N and is valid from N until the next rd strobe, where it is held.
  - An unmapped offset returns 0.
  - A read and a write to the same register in the same cycle returns the pre-write value.
- Commit write at edge N makes cfg_pending=1 after N. The earliest apply is edge N+1 if idle=1 at N+1; cfg_commit_done is high for the cycle after N+1.
- A shadow write coinciding with the apply edge: active takes the pre-write shadow value; shadow takes the new value; pending is not re-armed.
- The commit FSM ignores idle while in IDLE_CFG.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), and any pending commit is lost.

## Test plan
- Reset -> rd_weight all 0x01, rd_os_cnt=wr_os_cnt=0xFF, cfg_pending=0, ERR read = 0.
- Write RD_WT[0]=0x04030201 with idle=1, no commit:
  - reading RD_WT[0] returns 0x04030201 one cycle after reg_rd_en;
  - rd_weight[31:0] stays 0x01010101.
- Hold idle=0 and write CTRL=1:
  - cfg_pending=1 for 10 cycles while outputs are unchanged;
  - raise idle; next edge gives rd_weight[31:0]=0x04030201, one-cycle cfg_commit_done, cfg_pending=0.
- CTRL=1 then CTRL=3 while idle=0 -> cfg_pending=0, no pulse, and active is unchanged after idle rises.
- NUM_RD_CLIENTS=5: write RD_WT[1]=0xFFFFFFFF -> read returns 0x000000FF, and ERR stays 0.
- 300 writes to offset 0x0FC plus 2 writes to STATUS -> ERR reads 0x000002FF. A write to ERR then makes it read 0.
